dispense_rtc: RTL and testbench
===============================

Name: dispense_rtc

Overview:
Time-of-day counter that drives the seconds/minutes/hours bus consumed by the dose-time comparator. It divides the 50 MHz system clock to a 1 Hz tick and advances a 24-hour HH:MM:SS count. Software or front-panel logic can load a new time through a valid/ready set port, and a run enable can freeze the count.

Parameters:
CLK_HZ, 50000000, system clock cycles per second; prescaler terminal count is CLK_HZ-1
RESET_HOURS, 0, hours value loaded on reset (0..23)

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
run_en  in  1  1 = time advances; 0 = prescaler and time frozen
set_valid  in  1  request to load set_hours/set_minutes/set_seconds
set_hours  in  5  requested hours
set_minutes  in  6  requested minutes
set_seconds  in  6  requested seconds
set_ready  out  1  block can accept a set request this cycle
set_error  out  1  one-cycle pulse: request rejected as out of range
seconds  out  6  current seconds, 0..59
minutes  out  6  current minutes, 0..59
hours  out  5  current hours, 0..23
tick_1hz  out  1  one-cycle pulse on the cycle the time fields change by +1 s
day_wrap  out  1  one-cycle pulse when 23:59:59 rolls over to 00:00:00

Behaviour:
- Reset: hours=RESET_HOURS, minutes=0, seconds=0, prescaler=0, tick_1hz=0, day_wrap=0, set_error=0, set_ready=1, state=RUN. Reset wins over every other input.
- Prescaler: width is clog2(CLK_HZ). Increments each cycle while run_en=1 in RUN. At CLK_HZ-1 it wraps to 0 and the seconds field advances in the same edge. tick_1hz is registered high for exactly that one cycle.
- Carry chain: seconds 59->0 carries to minutes; minutes 59->0 carries to hours; hours 23->0 with minutes=59 and seconds=59 pulses day_wrap alongside tick_1hz. No field ever holds an illegal value.
- run_en=0: prescaler and time hold, and no ticks are produced. Resuming continues from the held prescaler value; it is not cleared.
- FSM states:
  - RUN: normal counting. set_ready=1.
  - LOAD: entered for exactly one cycle after an accepted set. set_ready=0, time holds, no tick. Returns to RUN.
- Set handshake: a request is accepted when set_valid and set_ready are both high at a posedge.
  - Range check: hours<=23, minutes<=59, seconds<=59. Pass: fields load the new values on that edge, prescaler clears to 0, FSM goes to LOAD. The first tick then follows CLK_HZ+1 cycles after the accept edge.
  - Fail: time and prescaler are untouched, set_error pulses one cycle, and the FSM stays in RUN.
  - set_valid while in LOAD is ignored; it is not queued.
- Simultaneous set accept and prescaler terminal count: the set wins, and tick_1hz/day_wrap are suppressed that cycle.
- A set is accepted regardless of run_en; the loaded time then holds until run_en=1.
- Outputs are registered with no combinational input-to-output path. Time fields are stable for at least CLK_HZ cycles between ticks when not being set.

Optional Feature:
DISPENSE_RTC_DAY_COUNT_EN: when defined, adds output day_count [2:0] (0..6, reset 0). It increments on each day_wrap and wraps 6->0, and a set request never changes it. When undefined the port and its register are absent and day_wrap behaviour is unchanged.

Decomposition:
- Shared package dispense_pkg holds:
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, SEC_W=6, MIN_W=6, HOUR_W=5
  - typedef rtc_state_t {RUN, LOAD}
  - packed struct time_t {hours, minutes, seconds}, so the dose-time comparator can share it.
- One natural sub-module: dispense_prescaler (counter with enable, sync clear and terminal-count pulse). The time carry chain stays in the top.

Test Plan:
- CLK_HZ=4, reset, run_en=1 -> first tick_1hz on 4th cycle after reset release, seconds 0->1. Ticks thereafter every 4 cycles.
- Set 23:59:58 (valid values) -> set_ready low 1 cycle. After 2 ticks time=00:00:00, day_wrap and tick_1hz both high on that cycle.
- set_hours=24, minutes=10, seconds=0 -> set_error pulses 1 cycle, time unchanged, next tick on original schedule.
- Assert set_valid on the exact terminal-count cycle with 08:00:00 -> time=08:00:00, no tick that cycle, next tick 5 cycles later.
- run_en=0 for 10 cycles mid-second -> no ticks, fields and prescaler held. On run_en=1, next tick comes after the remaining prescaler count.
- Assert reset during LOAD with set_valid high -> time returns to RESET_HOURS:00:00, set_ready=1 next cycle, no set_error.

Source files
------------

// File: rtl/dispense_rtc_pkg.sv
// Shared types and field limits for the dispenser time-of-day clock.
// Also consumed by the dose-time comparator through time_t.
package dispense_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } rtc_state_t;

    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
        logic [SEC_W-1:0]  seconds;
    } time_t;

    function automatic logic time_in_range(input time_t t);
        return (t.hours <= HOUR_MAX) && (t.minutes <= MIN_MAX) &&
               (t.seconds <= SEC_MAX);
    endfunction

endpackage

// File: rtl/dispense_rtc_if.sv
// Valid/ready port used to load a new time of day into dispense_rtc.
interface dispense_rtc_if;
    import dispense_pkg::*;

    logic              set_valid;
    logic [HOUR_W-1:0] set_hours;
    logic [MIN_W-1:0]  set_minutes;
    logic [SEC_W-1:0]  set_seconds;
    logic              set_ready;
    logic              set_error;

    modport master (
        output set_valid, set_hours, set_minutes, set_seconds,
        input  set_ready, set_error
    );

    modport slave (
        input  set_valid, set_hours, set_minutes, set_seconds,
        output set_ready, set_error
    );

endinterface

// File: rtl/dispense_rtc_prescaler.sv
// Free-running divider: counts 0..CLK_HZ-1 while enabled, sync clear,
// combinational terminal-count flag qualified by the enable.
module dispense_prescaler #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

    logic [CW-1:0] count_q, count_d;

    assign tc_o = en_i && (count_q == TERM);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == TERM) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dispense_rtc.sv
// 24-hour HH:MM:SS clock with 1 Hz prescaler and valid/ready time load.
// Optional DISPENSE_RTC_DAY_COUNT_EN adds a 0..6 day-of-week counter.
module dispense_rtc
    import dispense_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int RESET_HOURS = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run_en,
    dispense_rtc_if.slave     set_if,
    output logic [SEC_W-1:0]  seconds,
    output logic [MIN_W-1:0]  minutes,
    output logic [HOUR_W-1:0] hours,
    output logic              tick_1hz,
`ifdef DISPENSE_RTC_DAY_COUNT_EN
    output logic [2:0]        day_count,
`endif
    output logic              day_wrap
);

    rtc_state_t state_q, state_d;
    time_t      time_q, time_d;
    time_t      req;
    logic       tick_q, tick_d;
    logic       wrap_q, wrap_d;
    logic       err_q, err_d;
    logic       set_ok, set_bad;
    logic       presc_en, presc_tc;

    assign req.hours   = set_if.set_hours;
    assign req.minutes = set_if.set_minutes;
    assign req.seconds = set_if.set_seconds;

    assign set_ok   = set_if.set_valid && (state_q == RUN) && time_in_range(req);
    assign set_bad  = set_if.set_valid && (state_q == RUN) && !time_in_range(req);
    // An accepted load owns this edge, so the prescaler may not also terminate.
    assign presc_en = (state_q == RUN) && run_en && !set_ok;

    dispense_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_presc (
        .clock (clock),
        .reset (reset),
        .en_i  (presc_en),
        .clr_i (set_ok),
        .tc_o  (presc_tc)
    );

    always_comb begin
        state_d = RUN;
        time_d  = time_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (set_ok) begin
            time_d  = req;
            state_d = LOAD;
        end else begin
            err_d = set_bad;
            if (presc_tc) begin
                tick_d = 1'b1;
                if (time_q.seconds != SEC_MAX) begin
                    time_d.seconds = time_q.seconds + 1'b1;
                end else begin
                    time_d.seconds = '0;
                    if (time_q.minutes != MIN_MAX) begin
                        time_d.minutes = time_q.minutes + 1'b1;
                    end else begin
                        time_d.minutes = '0;
                        if (time_q.hours != HOUR_MAX) begin
                            time_d.hours = time_q.hours + 1'b1;
                        end else begin
                            time_d.hours = '0;
                            wrap_d       = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= RUN;
            time_q.hours   <= HOUR_W'(RESET_HOURS);
            time_q.minutes <= '0;
            time_q.seconds <= '0;
            tick_q         <= 1'b0;
            wrap_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

`ifdef DISPENSE_RTC_DAY_COUNT_EN
    logic [2:0] day_q, day_d;

    always_comb begin
        day_d = day_q;
        if (wrap_d) begin
            day_d = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            day_q <= '0;
        end else begin
            day_q <= day_d;
        end
    end

    assign day_count = day_q;
`endif

    assign set_if.set_ready = (state_q == RUN);
    assign set_if.set_error = err_q;
    assign seconds          = time_q.seconds;
    assign minutes          = time_q.minutes;
    assign hours            = time_q.hours;
    assign tick_1hz         = tick_q;
    assign day_wrap         = wrap_q;

endmodule

// File: tb/tb_dispense_rtc.sv
// Randomized bench for dispense_rtc against a seconds-of-day reference model.
module tb_dispense_rtc;

    localparam int CLK_HZ = 4;
    localparam int RST_H  = 5;
    localparam int DAY_S  = 86400;

    logic       clk = 1'b0;
    logic       reset;
    logic       run_en;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       tick_1hz;
    logic       day_wrap;
`ifdef DISPENSE_RTC_DAY_COUNT_EN
    logic [2:0] day_count;
`endif

    dispense_rtc_if u_if ();

    dispense_rtc #(
        .CLK_HZ      (CLK_HZ),
        .RESET_HOURS (RST_H)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .run_en    (run_en),
        .set_if    (u_if.slave),
        .seconds   (seconds),
        .minutes   (minutes),
        .hours     (hours),
        .tick_1hz  (tick_1hz),
`ifdef DISPENSE_RTC_DAY_COUNT_EN
        .day_count (day_count),
`endif
        .day_wrap  (day_wrap)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: time as seconds since midnight plus a clock phase counter.
    int m_sod   = 0;
    int m_phase = 0;
    bit m_load  = 0;
    bit m_tick  = 0;
    bit m_wrap  = 0;
    bit m_err   = 0;
    int m_day   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit run, input bit v,
                         input int h, input int m, input int s);
        bit was_load;
        m_tick = 0;
        m_wrap = 0;
        m_err  = 0;
        if (r) begin
            m_sod   = RST_H * 3600;
            m_phase = 0;
            m_load  = 0;
            m_day   = 0;
            return;
        end
        was_load = m_load;
        m_load   = 0;
        if (!was_load && v && h <= 23 && m <= 59 && s <= 59) begin
            m_sod   = h * 3600 + m * 60 + s;
            m_phase = 0;
            m_load  = 1;
        end else begin
            if (!was_load && v) m_err = 1;
            if (!was_load && run) begin
                if (m_phase == CLK_HZ - 1) begin
                    m_phase = 0;
                    m_tick  = 1;
                    if (m_sod == DAY_S - 1) begin
                        m_wrap = 1;
                        m_day  = (m_day + 1) % 7;
                    end
                    m_sod = (m_sod + 1) % DAY_S;
                end else begin
                    m_phase++;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit run, input bit v,
                       input int h, input int m, input int s);
        reset                = r;
        run_en               = run;
        u_if.set_valid       = v;
        u_if.set_hours       = 5'(h);
        u_if.set_minutes     = 6'(m);
        u_if.set_seconds     = 6'(s);
        @(posedge clk);
        model(r, run, v, h & 31, m & 63, s & 63);
        #1;
        chk("hours", int'(hours), m_sod / 3600);
        chk("minutes", int'(minutes), (m_sod / 60) % 60);
        chk("seconds", int'(seconds), m_sod % 60);
        chk("tick_1hz", int'(tick_1hz), int'(m_tick));
        chk("day_wrap", int'(day_wrap), int'(m_wrap));
        chk("set_error", int'(u_if.set_error), int'(m_err));
        chk("set_ready", int'(u_if.set_ready), int'(!m_load));
`ifdef DISPENSE_RTC_DAY_COUNT_EN
        chk("day_count", int'(day_count), m_day);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        int h, m, s;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("rst_hours", int'(hours), RST_H);

        // first tick on the 4th cycle after release
        idle(3);
        chk("pre_tick_sec", int'(seconds), 0);
        idle(1);
        chk("first_tick", int'(tick_1hz), 1);
        chk("first_sec", int'(seconds), 1);
        idle(8);

        // day wrap from 23:59:58
        cyc(0, 1, 1, 23, 59, 58);
        chk("load_ready", int'(u_if.set_ready), 0);
        idle(1 + 2 * CLK_HZ);
        chk("wrap_pulse", int'(day_wrap), 1);
        chk("wrap_hms", {hours, minutes, seconds}, 0);

        // out-of-range request
        cyc(0, 1, 1, 24, 10, 0);
        chk("bad_err", int'(u_if.set_error), 1);
        idle(6);

        // set on the exact terminal-count cycle
        while (m_phase != CLK_HZ - 1) idle(1);
        cyc(0, 1, 1, 8, 0, 0);
        chk("tc_set_tick", int'(tick_1hz), 0);
        chk("tc_set_hours", int'(hours), 8);
        idle(CLK_HZ + 1);
        chk("tc_set_next", int'(tick_1hz), 1);

        // freeze mid-second
        idle(2);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0);
        idle(6);

        // reset during LOAD with a pending request
        cyc(0, 1, 1, 12, 30, 30);
        cyc(1, 1, 1, 12, 30, 30);
        chk("rst_in_load_h", int'(hours), RST_H);
        cyc(0, 1, 0, 0, 0, 0);
        chk("rst_ready", int'(u_if.set_ready), 1);

        // set while frozen holds until run resumes
        cyc(0, 0, 1, 1, 2, 3);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
        idle(8);

        for (int i = 0; i < 3000; i++) begin
            bit r, run, v;
            r   = ($urandom_range(0, 299) == 0);
            run = ($urandom_range(0, 7) != 0);
            v   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                h = 23;
                m = 59;
                s = $urandom_range(50, 59);
            end else begin
                h = $urandom_range(0, 31);
                m = $urandom_range(0, 63);
                s = $urandom_range(0, 63);
            end
            cyc(r, run, v, h, m, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
